// File: rtl/dff_en_rr_arbiter.sv
// Round-robin arbiter in front of a shared enable-gated W-bit register.
// The winner's data is loaded on the edge it is granted. A requester that
// asks for lock can take up to MAX_HOLD grants in a row before it must
// rotate.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | rotating arbitration, scanning from ptr+1 with wrap
// ST_LOCKED | burst in progress, only the current owner can be granted
module dff_en_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 4,
    localparam int OW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*W-1:0] d,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      q,
    output logic [OW-1:0]     owner,
    output logic              locked
);

    // The hold counter never needs to reach MAX_HOLD. The burst ends on the
    // grant that finds the counter at MAX_HOLD-1.
    localparam int            HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [W-1:0]    q_q, q_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic            win_vld;
    logic [OW-1:0]   win_idx;
    logic [OW-1:0]   cand;
    int              idx;

    // Pick this cycle's winner. A lock burst shuts out every other requester.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        idx     = 0;
        if (state_q == ST_LOCKED) begin
            if (req[owner_q]) begin
                win_vld = 1'b1;
                win_idx = owner_q;
            end
        end else begin
            for (int i = 1; i <= NREQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= NREQ) idx = idx - NREQ;
                cand = OW'(idx);
                if (!win_vld && req[cand]) begin
                    win_vld = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    // Register enable/data select, and the lock burst FSM.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        q_d        = q_q;
        gnt_d      = '0;

        if (win_vld) begin
            q_d            = d[win_idx*W +: W];
            gnt_d[win_idx] = 1'b1;
            owner_d        = win_idx;
            ptr_d          = win_idx;
        end

        if (state_q == ST_IDLE) begin
            if (win_vld && lock[win_idx] && (MAX_HOLD > 1)) begin
                state_d    = ST_LOCKED;
                hold_cnt_d = HW'(1);
            end
        end else begin
            if (win_vld && lock[win_idx] && (hold_cnt_q < HOLD_LAST)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end else begin
                // The owner dropped its request, dropped lock, or used up its
                // burst. Any grant made on this edge still stands.
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        end
    end

    // State flops. ptr resets to NREQ-1 so the first scan starts at requester 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            ptr_q      <= OW'(NREQ - 1);
            owner_q    <= '0;
            q_q        <= '0;
            gnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            q_q        <= q_d;
            gnt_q      <= gnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign q      = q_q;
    assign owner  = owner_q;
    assign locked = (state_q == ST_LOCKED);

endmodule
